// File: rtl/shader_pkg.sv
// Shared constants and FSM encoding for the triangle scanline sequencer.
// Coordinates are Q11.5, so an integer row is the coordinate with the fraction dropped.
package shader_pkg;

  localparam int COORD_W          = 16;
  localparam int FRAC_BITS        = 5;
  localparam int ROW_W            = COORD_W - FRAC_BITS;
  localparam int SCREEN_H_DEFAULT = 480;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_WAIT_RELEASE,
    ST_NEXT,
    ST_FINISH
  } seq_state_e;

  function automatic logic [ROW_W-1:0] coord_to_row(input logic [COORD_W-1:0] c);
    return c[COORD_W-1:FRAC_BITS];
  endfunction

endpackage

// File: rtl/scanline_sequencer.sv
// Walks a y-sorted triangle one row at a time, presenting the row's bounding edges
// to a sibling span unit over a level start/done handshake.
//
// state           | meaning
// ST_IDLE         | waiting for start, vertices latched on acceptance
// ST_SETUP        | compute first/last row, reject unsorted vertices
// ST_ISSUE        | raise span_start, arm the timeout
// ST_WAIT_DONE    | span in flight, timeout counting down
// ST_WAIT_RELEASE | span acknowledged, waiting for span_done to fall
// ST_NEXT         | advance to the next row or finish
// ST_FINISH       | one-cycle done pulse
module scanline_sequencer
  import shader_pkg::*;
#(
  parameter int SCREEN_H = SCREEN_H_DEFAULT,
  parameter int TIMEOUT  = 4095
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [COORD_W-1:0] v0x,
  input  logic [COORD_W-1:0] v0y,
  input  logic [COORD_W-1:0] v1x,
  input  logic [COORD_W-1:0] v1y,
  input  logic [COORD_W-1:0] v2x,
  input  logic [COORD_W-1:0] v2y,
  input  logic               span_done,
  output logic               span_start,
  output logic [COORD_W-1:0] span_y,
  output logic [COORD_W-1:0] span_pax,
  output logic [COORD_W-1:0] span_pay,
  output logic [COORD_W-1:0] span_pbx,
  output logic [COORD_W-1:0] span_pby,
  output logic [COORD_W-1:0] span_pcx,
  output logic [COORD_W-1:0] span_pcy,
  output logic [COORD_W-1:0] span_pdx,
  output logic [COORD_W-1:0] span_pdy,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [ROW_W-1:0]   rows_drawn
);

  localparam int               TMR_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);
  localparam logic [ROW_W-1:0] ROW_MAX  = ROW_W'(SCREEN_H - 1);

  seq_state_e state, state_nxt;

  logic [COORD_W-1:0] x0, y0, x1, y1, x2, y2;
  logic [ROW_W-1:0]   row, last;
  logic [TMR_W-1:0]   tmr;

  logic             latch_en, setup_en, tmr_load, tmr_dec, row_inc, rows_inc, err_set;
  logic [ROW_W-1:0] row_setup, v2_row, last_setup;
  logic             unsorted, upper_half;

  assign row_setup  = coord_to_row(y0);
  assign v2_row     = coord_to_row(y2);
  assign last_setup = (v2_row > ROW_MAX) ? ROW_MAX : v2_row;
  assign unsorted   = (y0 > y1) || (y1 > y2);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    latch_en  = 1'b0;
    setup_en  = 1'b0;
    tmr_load  = 1'b0;
    tmr_dec   = 1'b0;
    row_inc   = 1'b0;
    rows_inc  = 1'b0;
    err_set   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          latch_en  = 1'b1;
          state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: begin
        setup_en = 1'b1;
        if (unsorted) begin
          err_set   = 1'b1;
          state_nxt = ST_FINISH;
        end else if (row_setup > last_setup) begin
          state_nxt = ST_FINISH;
        end else begin
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        tmr_load  = 1'b1;
        state_nxt = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        // span_done wins over a timeout landing on the same cycle
        if (span_done) begin
          state_nxt = ST_WAIT_RELEASE;
        end else if (tmr == '0) begin
          err_set   = 1'b1;
          state_nxt = ST_FINISH;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_WAIT_RELEASE: begin
        if (!span_done) begin
          rows_inc  = 1'b1;
          state_nxt = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (row == last) begin
          state_nxt = ST_FINISH;
        end else begin
          row_inc   = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_FINISH: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x0         <= '0;
      y0         <= '0;
      x1         <= '0;
      y1         <= '0;
      x2         <= '0;
      y2         <= '0;
      row        <= '0;
      last       <= '0;
      tmr        <= '0;
      rows_drawn <= '0;
      error      <= 1'b0;
    end else begin
      if (latch_en) begin
        x0         <= v0x;
        y0         <= v0y;
        x1         <= v1x;
        y1         <= v1y;
        x2         <= v2x;
        y2         <= v2y;
        rows_drawn <= '0;
        error      <= 1'b0;
      end
      if (setup_en) begin
        row  <= row_setup;
        last <= last_setup;
      end
      if (row_inc) row <= row + 1'b1;
      if (tmr_load)     tmr <= TMR_LOAD;
      else if (tmr_dec) tmr <= tmr - 1'b1;
      if (rows_inc) rows_drawn <= rows_drawn + 1'b1;
      if (err_set)  error <= 1'b1;
    end
  end

  // Outputs derive from state and latched registers, so reset clears them at once.
  assign span_start = (state == ST_ISSUE) || (state == ST_WAIT_DONE);
  assign busy       = (state != ST_IDLE);
  assign done       = (state == ST_FINISH);

  assign upper_half = (row < coord_to_row(y1));
  assign span_y     = {{(COORD_W - ROW_W){1'b0}}, row};
  assign span_pax   = x0;
  assign span_pay   = y0;
  assign span_pbx   = x2;
  assign span_pby   = y2;
  assign span_pcx   = upper_half ? x0 : x1;
  assign span_pcy   = upper_half ? y0 : y1;
  assign span_pdx   = upper_half ? x1 : x2;
  assign span_pdy   = upper_half ? y1 : y2;

endmodule
